mem_arbiter: RTL and testbench

- Sequences the single shared instruction/data memory of the multi-cycle stack MIPS.
- Two requesters share the memory: instruction fetch (IF/PUSH operand read) and data (push-operand read, pop write-back).
- Runs one transaction at a time against a fixed-latency memory and returns a one-cycle ack to the winning requester.
- Sits between the controller/datapath and the memory; the datapath's PorI address mux is replaced by this block's grant.

---
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Signal bundle shared by the fetch/data requesters, the memory arbiter and the
// fixed-latency instruction/data memory.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
);
    // Fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    // Data requester
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    // Memory side
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;

    // Status
    logic              busy;
    logic              gnt_d;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ack, d_rdata, d_ack,
        output mem_addr, mem_wdata, mem_read, mem_write, busy, gnt_d
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ack, d_rdata, d_ack,
        input  mem_addr, mem_wdata, mem_read, mem_write, busy, gnt_d
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shared instruction/data memory arbiter: one fixed-latency transaction at a time,
// one-cycle ack to the winner. Define ARB_RR_EN for round-robin; default is data priority.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int unsigned     CntW    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e            r_state,    w_state_nxt;
    logic [CntW-1:0]   r_cnt,      w_cnt_nxt;
    logic              r_gnt_d,    w_gnt_d_nxt;
    logic              r_we,       w_we_nxt;
    logic [ADDR_W-1:0] r_addr,     w_addr_nxt;
    logic [DATA_W-1:0] r_wdata,    w_wdata_nxt;
    logic [DATA_W-1:0] r_if_rdata, w_if_rdata_nxt;
    logic [DATA_W-1:0] r_d_rdata,  w_d_rdata_nxt;
    logic              w_any_req;
    logic              w_pick_d;

    assign w_any_req = bus.if_req | bus.d_req;

`ifdef ARB_RR_EN
    logic r_last_d, w_last_d_nxt;

    // On a tie the requester that did not win last time goes first.
    assign w_pick_d = bus.d_req & (~bus.if_req | ~r_last_d);

    always_comb begin
        w_last_d_nxt = r_last_d;
        if (r_state == StIdle && w_any_req) begin
            w_last_d_nxt = w_pick_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_d <= 1'b1;
        end else begin
            r_last_d <= w_last_d_nxt;
        end
    end
`else
    assign w_pick_d = bus.d_req;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_gnt_d_nxt    = r_gnt_d;
        w_we_nxt       = r_we;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_if_rdata_nxt = r_if_rdata;
        w_d_rdata_nxt  = r_d_rdata;
        unique case (r_state)
            StIdle: begin
                if (w_any_req) begin
                    w_state_nxt = StBusy;
                    w_cnt_nxt   = CntLoad;
                    w_gnt_d_nxt = w_pick_d;
                    if (w_pick_d) begin
                        w_we_nxt    = bus.d_we;
                        w_addr_nxt  = bus.d_addr;
                        w_wdata_nxt = bus.d_wdata;
                    end else begin
                        w_we_nxt   = 1'b0;
                        w_addr_nxt = bus.if_addr;
                    end
                end
            end
            StBusy: begin
                if (r_cnt == '0) begin
                    w_state_nxt = StDone;
                    // Memory data is only valid in the final access cycle.
                    if (!r_we) begin
                        if (r_gnt_d) begin
                            w_d_rdata_nxt = bus.mem_rdata;
                        end else begin
                            w_if_rdata_nxt = bus.mem_rdata;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_gnt_d    <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_gnt_d    <= w_gnt_d_nxt;
            r_we       <= w_we_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_if_rdata <= w_if_rdata_nxt;
            r_d_rdata  <= w_d_rdata_nxt;
        end
    end

    assign bus.mem_read  = (r_state == StBusy) & ~r_we;
    assign bus.mem_write = (r_state == StBusy) & r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.if_ack    = (r_state == StDone) & ~r_gnt_d;
    assign bus.d_ack     = (r_state == StDone) & r_gnt_d;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.busy      = (r_state != StIdle);
    assign bus.gnt_d     = r_gnt_d;

    a_one_ack : assert property (@(posedge clk) disable iff (rst) !(bus.if_ack && bus.d_ack));
    a_one_strobe : assert property (@(posedge clk) disable iff (rst)
                                    !(bus.mem_read && bus.mem_write));
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model plus directed literal checks
// and randomized requester traffic.
module tb_mem_arbiter;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;
    localparam int          LAT    = 2;

    logic clk = 1'b0;
    logic rst;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .MEM_LAT(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0] mem_array [0:31];

    // Transaction-level model: a transaction granted at edge s is busy after
    // edges s..s+LAT-1, acks after edge s+LAT, and the next grant is possible
    // at edge s+LAT+2.
    int                edge_no;
    int                m_start;
    int                rel;
    bit                m_active;
    bit                m_win_d;
    bit                m_we;
    bit                m_last_d;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_if_rdata;
    logic [DATA_W-1:0] m_d_rdata;
    bit                e_busy, e_strobe, e_ack_f, e_ack_d, e_infl_f, e_infl_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rst) begin
            edge_no    = 0;
            m_active   = 1'b0;
            m_win_d    = 1'b0;
            m_we       = 1'b0;
            m_last_d   = 1'b1;
            m_addr     = '0;
            m_wdata    = '0;
            m_if_rdata = '0;
            m_d_rdata  = '0;
        end else begin
            edge_no++;
            if (m_active) begin
                rel = edge_no - m_start;
                if (rel == LAT) begin
                    if (m_we) mem_array[m_addr] = m_wdata;
                    else if (m_win_d) m_d_rdata = mem_array[m_addr];
                    else m_if_rdata = mem_array[m_addr];
                end
                if (rel >= LAT + 2) m_active = 1'b0;
            end
            if (!m_active && (bus.if_req || bus.d_req)) begin
`ifdef ARB_RR_EN
                m_win_d = (bus.if_req && bus.d_req) ? !m_last_d : bus.d_req;
`else
                m_win_d = bus.d_req;
`endif
                m_last_d = m_win_d;
                m_we     = m_win_d && bus.d_we;
                m_addr   = m_win_d ? bus.d_addr : bus.if_addr;
                if (m_win_d) m_wdata = bus.d_wdata;
                m_active = 1'b1;
                m_start  = edge_no;
            end
        end
        rel      = m_active ? edge_no - m_start : LAT + 2;
        e_busy   = (rel <= LAT);
        e_strobe = (rel < LAT);
        e_ack_f  = (rel == LAT) && !m_win_d;
        e_ack_d  = (rel == LAT) && m_win_d;
        e_infl_f = e_busy && !m_win_d;
        e_infl_d = e_busy && m_win_d;

        check("busy", 32'(bus.busy), 32'(e_busy));
        check("mem_read", 32'(bus.mem_read), 32'(e_strobe && !m_we));
        check("mem_write", 32'(bus.mem_write), 32'(e_strobe && m_we));
        check("if_ack", 32'(bus.if_ack), 32'(e_ack_f));
        check("d_ack", 32'(bus.d_ack), 32'(e_ack_d));
        check("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
        check("gnt_d", 32'(bus.gnt_d), 32'(m_win_d));
        check("if_rdata", 32'(bus.if_rdata), 32'(m_if_rdata));
        check("d_rdata", 32'(bus.d_rdata), 32'(m_d_rdata));
        if (e_strobe && m_we) check("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));

        // Memory returns valid data only in the last access cycle; garbage otherwise.
        if (!rst && m_active && rel == LAT - 1 && !m_we) bus.mem_rdata = mem_array[m_addr];
        else bus.mem_rdata = DATA_W'($urandom);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rand_drive();
        if (e_ack_f) begin
            if ($urandom_range(0, 1) == 1) begin
                bus.if_req  = 1'b1;
                bus.if_addr = ADDR_W'($urandom);
            end else begin
                bus.if_req = 1'b0;
            end
        end else if (e_infl_f) begin
            if (bus.if_req && $urandom_range(0, 7) == 0) bus.if_req = 1'b0;
            bus.if_addr = ADDR_W'($urandom);
        end else if (!bus.if_req && $urandom_range(0, 2) == 0) begin
            bus.if_req  = 1'b1;
            bus.if_addr = ADDR_W'($urandom);
        end

        if (e_ack_d) begin
            if ($urandom_range(0, 1) == 1) begin
                bus.d_req   = 1'b1;
                bus.d_we    = 1'($urandom);
                bus.d_addr  = ADDR_W'($urandom_range(0, 7));
                bus.d_wdata = DATA_W'($urandom);
            end else begin
                bus.d_req = 1'b0;
            end
        end else if (e_infl_d) begin
            if (bus.d_req && $urandom_range(0, 7) == 0) bus.d_req = 1'b0;
            bus.d_addr  = ADDR_W'($urandom_range(0, 7));
            bus.d_wdata = DATA_W'($urandom);
        end else if (!bus.d_req && $urandom_range(0, 2) == 0) begin
            bus.d_req   = 1'b1;
            bus.d_we    = 1'($urandom);
            bus.d_addr  = ADDR_W'($urandom_range(0, 7));
            bus.d_wdata = DATA_W'($urandom);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        int          cnt;
        logic [3:0]  seq;
        logic [3:0]  exp_seq;

        rst           = 1'b1;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_rdata = '0;
        for (int i = 0; i < 32; i++) mem_array[i] = DATA_W'($urandom);

        // Reset then idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) tick();
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_strobes", 32'({bus.mem_read, bus.mem_write}), 32'd0);
        check("idle_acks", 32'({bus.if_ack, bus.d_ack}), 32'd0);
        check("idle_rdata", 32'({bus.if_rdata, bus.d_rdata}), 32'd0);
        check("idle_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("idle_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("idle_gnt_d", 32'(bus.gnt_d), 32'd0);

        // Fetch read of address 3
        mem_array[3] = 8'hA5;
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = 5'd3;
        tick();
        check("fetch_rd1", 32'(bus.mem_read), 32'd1);
        check("fetch_addr", 32'(bus.mem_addr), 32'd3);
        tick();
        check("fetch_rd2", 32'(bus.mem_read), 32'd1);
        tick();
        check("fetch_ack", 32'(bus.if_ack), 32'd1);
        check("fetch_rd_off", 32'(bus.mem_read), 32'd0);
        check("fetch_rdata", 32'(bus.if_rdata), 32'hA5);
        @(negedge clk);
        bus.if_req = 1'b0;
        tick();
        check("fetch_ack_off", 32'(bus.if_ack), 32'd0);
        check("fetch_rdata_held", 32'(bus.if_rdata), 32'hA5);

        // Data write 0x3C to address 31
        @(negedge clk);
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 5'd31;
        bus.d_wdata = 8'h3C;
        tick();
        check("wr_strobe1", 32'({bus.mem_write, bus.mem_read}), 32'b10);
        check("wr_addr", 32'(bus.mem_addr), 32'd31);
        check("wr_wdata", 32'(bus.mem_wdata), 32'h3C);
        tick();
        check("wr_strobe2", 32'({bus.mem_write, bus.mem_read}), 32'b10);
        tick();
        check("wr_ack", 32'(bus.d_ack), 32'd1);
        check("wr_rdata_kept", 32'(bus.d_rdata), 32'd0);
        @(negedge clk);
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        tick();

        // Read back address 31
        @(negedge clk);
        bus.d_req  = 1'b1;
        bus.d_addr = 5'd31;
        repeat (3) tick();
        check("rdback_ack", 32'(bus.d_ack), 32'd1);
        check("rdback_data", 32'(bus.d_rdata), 32'h3C);
        @(negedge clk);
        bus.d_req = 1'b0;
        tick();

        // Drop d_req mid-transaction
        mem_array[9] = 8'hC3;
        @(negedge clk);
        bus.d_req  = 1'b1;
        bus.d_addr = 5'd9;
        tick();
        @(negedge clk);
        bus.d_req  = 1'b0;
        bus.d_addr = ADDR_W'($urandom);
        n = 0;
        repeat (3) begin
            tick();
            if (bus.d_ack) n++;
        end
        check("drop_ack_count", 32'(n), 32'd1);
        check("drop_rdata", 32'(bus.d_rdata), 32'hC3);

        // Contention, both requests held
`ifdef ARB_RR_EN
        exp_seq = 4'b1010;
`else
        exp_seq = 4'b0111;
`endif
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = 5'd4;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 5'd5;
        cnt = 0;
        seq = '0;
        for (int c = 0; c < 40 && cnt < 4; c++) begin
            tick();
            if (bus.if_ack || bus.d_ack) begin
                seq[cnt] = bus.d_ack;
                cnt++;
                @(negedge clk);
`ifndef ARB_RR_EN
                if (cnt == 3) bus.d_req = 1'b0;
`endif
                if (cnt == 4) begin
                    bus.if_req = 1'b0;
                    bus.d_req  = 1'b0;
                end
            end
        end
        check("contention_count", 32'(cnt), 32'd4);
        check("contention_order", 32'(seq), 32'(exp_seq));
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        tick();

        // Reset in the second BUSY cycle of a fetch
        mem_array[7] = 8'h5A;
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = 5'd7;
        tick();
        tick();
        check("rstmid_rd_before", 32'(bus.mem_read), 32'd1);
        rst = 1'b1;
        #1;
        check("rstmid_strobe", 32'({bus.mem_read, bus.mem_write}), 32'd0);
        check("rstmid_busy", 32'(bus.busy), 32'd0);
        check("rstmid_ack", 32'(bus.if_ack), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (6) begin
            tick();
            if (bus.if_ack) begin
                n++;
                @(negedge clk);
                bus.if_req = 1'b0;
            end
        end
        check("rstmid_reserve_acks", 32'(n), 32'd1);
        check("rstmid_rdata", 32'(bus.if_rdata), 32'h5A);
        @(negedge clk);
        bus.if_req = 1'b0;

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rand_drive();
        end
        @(negedge clk);
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
